mac_horner: RTL and testbench

Parametrised-order polynomial evaluator, the generalised successor of the fixed fifth-order MAC. It computes y = g·(c0 + c1·t + … + cN·t^N) with a fully pipelined Horner chain, one sample per clock. A double-buffered coefficient bank allows run-time updates without mixing coefficient sets within a sample. It sits in the signal-generator datapath between the envelope time counter and the output scaler.

---
 rtl/mac_horner.sv | 160 ++++++++++++++++
 tb/tb_mac_horner.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_horner.sv
// Pipelined Horner-chain polynomial evaluator y = g * sum(c_k * t^k), one sample per clock,
// with a shadow/active coefficient bank swapped only once the coefficient stages are empty.
module mac_horner #(
  parameter int BC = 16,
  parameter int BT = 12,
  parameter int BY = 10,
  parameter int N  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BT-1:0]          t_in,
  input  logic                   t_valid,
  output logic                   t_ready,
  input  logic                   c_we,
  input  logic [$clog2(N+1)-1:0] c_addr,
  input  logic [BC-1:0]          c_data,
  input  logic                   c_commit,
  input  logic [BC-1:0]          g_in,
  output logic [BY-1:0]          y_out,
  output logic                   y_valid,
  output logic                   ovf,
  output logic                   c_busy
);
  localparam int BA = BC + 4;
  localparam int PW = BA + BT + 1;
  localparam int GW = BA + BC;
  localparam int SH = 2 * (BC - 1) - (BY - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, COPY} state_t;
  state_t state, state_nx;

  logic signed [BC-1:0] shadow [0:N];
  logic signed [BC-1:0] active [0:N];

  logic signed [BA-1:0] acc_p [0:N];
  logic        [BT-1:0] t_p   [0:N-1];
  logic signed [BC-1:0] g_p   [0:N];
  logic signed [PW-1:0] sum   [1:N];
  logic        [N:0]    vld_p;
  logic        [N:0]    ovf_p;
  logic signed [GW-1:0] prod_pg;
  logic                 vld_pg, ovf_pg;
  logic                 ready_en, copy_en, accept, coef_busy;

  function automatic logic sat_acc_hit(input logic signed [PW-1:0] v);
    return !((&v[PW-1:BA-1]) || !(|v[PW-1:BA-1]));
  endfunction

  function automatic logic signed [BA-1:0] sat_acc(input logic signed [PW-1:0] v);
    if (sat_acc_hit(v)) return v[PW-1] ? {1'b1, {(BA-1){1'b0}}} : {1'b0, {(BA-1){1'b1}}};
    return v[BA-1:0];
  endfunction

  function automatic logic sat_out_hit(input logic signed [GW-1:0] v);
    return !((&v[GW-1:BY-1]) || !(|v[GW-1:BY-1]));
  endfunction

  function automatic logic signed [BY-1:0] sat_out(input logic signed [GW-1:0] v);
    if (sat_out_hit(v)) return v[GW-1] ? {1'b1, {(BY-1){1'b0}}} : {1'b0, {(BY-1){1'b1}}};
    return v[BY-1:0];
  endfunction

  assign accept = t_valid & t_ready;

  // Horner step j consumes c_(N-j): floor(acc*t/2^BT) + c, t treated as a non-negative fraction
  always_comb begin
    for (int j = 1; j <= N; j++) begin
      sum[j] = ((PW'(acc_p[j-1]) * PW'($signed({1'b0, t_p[j-1]}))) >>> BT) + PW'(active[N-j]);
    end
  end

  // Stage 0 loads c_N; stages 1..N run the chain; gain product follows stage N
  always_ff @(posedge clk) begin
    acc_p[0] <= BA'(active[N]);
    t_p[0]   <= t_in;
    g_p[0]   <= g_in;
    for (int j = 1; j <= N; j++) begin
      acc_p[j] <= sat_acc(sum[j]);
      g_p[j]   <= g_p[j-1];
    end
    for (int j = 1; j < N; j++) t_p[j] <= t_p[j-1];
    prod_pg <= GW'(acc_p[N]) * GW'(g_p[N]);
  end

  // Valid and sticky overflow travel with each sample; output stage rescales and saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p   <= '0;
      ovf_p   <= '0;
      vld_pg  <= 1'b0;
      ovf_pg  <= 1'b0;
      y_valid <= 1'b0;
      ovf     <= 1'b0;
      y_out   <= '0;
    end else begin
      vld_p[0] <= accept;
      ovf_p[0] <= 1'b0;
      for (int j = 1; j <= N; j++) begin
        vld_p[j] <= vld_p[j-1];
        ovf_p[j] <= ovf_p[j-1] | (vld_p[j-1] & sat_acc_hit(sum[j]));
      end
      vld_pg  <= vld_p[N];
      ovf_pg  <= ovf_p[N];
      y_valid <= vld_pg;
      ovf     <= ovf_pg | (vld_pg & sat_out_hit(prod_pg >>> SH));
      y_out   <= sat_out(prod_pg >>> SH);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= N; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (c_we && (int'(c_addr) <= N)) shadow[c_addr] <= c_data;
      if (copy_en) begin
        for (int k = 0; k <= N; k++) active[k] <= shadow[k];
      end
    end
  end

  // Only stages 0..N read the active bank, so the copy may overlap the gain/output stages
  assign coef_busy = |vld_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nx;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    copy_en  = 1'b0;
    c_busy   = 1'b0;
    t_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        t_ready = ready_en;
        if (c_commit) state_nx = DRAIN;
      end
      DRAIN: begin
        c_busy = 1'b1;
        if (!coef_busy) state_nx = COPY;
      end
      COPY: begin
        c_busy   = 1'b1;
        copy_en  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_horner.sv
// Bench for mac_horner: directed polynomial cases, randomized streams, coefficient
// commit mid-ramp and reset mid-stream, checked against a plain-arithmetic polynomial model.
module tb_mac_horner;
  localparam int BC = 16;
  localparam int BT = 12;
  localparam int BY = 10;
  localparam int N  = 5;
  localparam int AW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [BT-1:0] t_in;
  logic          t_valid;
  logic          t_ready;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [BC-1:0] c_data;
  logic          c_commit;
  logic [BC-1:0] g_in;
  logic [BY-1:0] y_out;
  logic          y_valid;
  logic          ovf;
  logic          c_busy;

  mac_horner #(.BC(BC), .BT(BT), .BY(BY), .N(N)) dut (
    .clk(clk), .rst(rst), .t_in(t_in), .t_valid(t_valid), .t_ready(t_ready),
    .c_we(c_we), .c_addr(c_addr), .c_data(c_data), .c_commit(c_commit), .g_in(g_in),
    .y_out(y_out), .y_valid(y_valid), .ovf(ovf), .c_busy(c_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: evaluate the polynomial with integer floor arithmetic and range clamps
  longint m_shadow [0:N] = '{default: 0};
  longint m_active [0:N] = '{default: 0};
  longint cs       [0:N];

  function automatic longint fdiv(input longint a, input int sh);
    longint d = longint'(1) << sh;
    longint q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic void model(input longint t, input longint g, output longint y, output bit o);
    longint amax = (longint'(1) << (BC + 3)) - 1;
    longint ymax = (longint'(1) << (BY - 1)) - 1;
    longint acc  = m_active[N];
    o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      acc = fdiv(acc * t, BT) + m_active[k];
      if (acc > amax) begin acc = amax; o = 1'b1; end
      else if (acc < -amax - 1) begin acc = -amax - 1; o = 1'b1; end
    end
    y = fdiv(acc * g, 2 * (BC - 1) - (BY - 1));
    if (y > ymax) begin y = ymax; o = 1'b1; end
    else if (y < -ymax - 1) begin y = -ymax - 1; o = 1'b1; end
  endfunction

  typedef struct {
    longint y;
    bit     o;
    int     edge_no;
  } exp_t;

  exp_t   eq [$];
  exp_t   e_m;
  int     cyc = 0;
  bit     busy_q = 1'b0;
  int     out_cnt = 0;
  longint last_y = 0;
  bit     last_o = 1'b0;

  // Scoreboard: outputs checked, then bank-swap tracking, then the sample about to be accepted
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      busy_q = 1'b0;
    end else begin
      if (y_valid) begin
        out_cnt++;
        last_y = longint'($signed(y_out));
        last_o = ovf;
        if (eq.size() == 0) begin
          check_val("spurious_output", 1, 0);
        end else begin
          e_m = eq.pop_front();
          check_val("y", last_y, e_m.y);
          check_val("ovf", longint'(last_o), longint'(e_m.o));
          check_val("latency", longint'((cyc - 1) - e_m.edge_no), N + 2);
        end
      end
      if (busy_q && !c_busy) m_active = m_shadow;
      busy_q = c_busy;
      if (t_valid && t_ready) begin
        model(longint'(t_in), longint'($signed(g_in)), e_m.y, e_m.o);
        e_m.edge_no = cyc;
        eq.push_back(e_m);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input longint v);
    c_we   = 1'b1;
    c_addr = AW'(k);
    c_data = BC'(v);
    if (k <= N) m_shadow[k] = v;
    tick();
    c_we = 1'b0;
  endtask

  task automatic commit_wait();
    int n = 0;
    c_commit = 1'b1;
    tick();
    c_commit = 1'b0;
    while (c_busy && n < 40) begin
      tick();
      n++;
    end
    check_val("commit_done", longint'(c_busy), 0);
  endtask

  task automatic load_cs();
    for (int k = 0; k <= N; k++) wr(k, cs[k]);
    wr(N + 1, 16'h1234);
    commit_wait();
  endtask

  task automatic send_one(input longint t, input longint g, output longint y, output bit o);
    int n  = 0;
    int c0 = out_cnt;
    t_in    = BT'(t);
    g_in    = BC'(g);
    t_valid = 1'b1;
    tick();
    t_valid = 1'b0;
    while (out_cnt == c0 && n < 30) begin
      tick();
      n++;
    end
    check_val("response_seen", longint'(out_cnt != c0), 1);
    y = last_y;
    o = last_o;
  endtask

  task automatic directed(input string tag, input longint c0, input longint c1,
                          input longint t, input longint g, input longint ey, input bit eo);
    longint y;
    bit     o;
    for (int k = 0; k <= N; k++) cs[k] = 0;
    cs[0] = c0;
    cs[1] = c1;
    load_cs();
    send_one(t, g, y, o);
    check_val({tag, "_y"}, y, ey);
    check_val({tag, "_ovf"}, longint'(o), longint'(eo));
  endtask

  task automatic rand_set(input int shmax);
    for (int k = 0; k <= N; k++)
      cs[k] = longint'($signed(BC'($urandom))) >>> $urandom_range(0, shmax);
  endtask

  task automatic rand_stream(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      t_valid = ($urandom_range(0, 3) != 0);
      t_in    = BT'($urandom);
      g_in    = BC'($urandom);
      tick();
    end
    t_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (eq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check_val("queue_empty", eq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint new_cs [0:N];
    longint y;
    bit     o;
    int     low_cnt;
    int     acc_cnt;

    rst = 1'b1; t_in = '0; t_valid = 1'b0; c_we = 1'b0; c_addr = '0;
    c_data = '0; c_commit = 1'b0; g_in = '0;
    #2;
    check_val("rst_y_out", longint'(y_out), 0);
    check_val("rst_y_valid", longint'(y_valid), 0);
    check_val("rst_ovf", longint'(ovf), 0);
    check_val("rst_c_busy", longint'(c_busy), 0);
    check_val("rst_t_ready", longint'(t_ready), 0);
    tick();
    tick();
    rst = 1'b0;
    check_val("ready_before_edge", longint'(t_ready), 0);
    tick();
    check_val("ready_after_edge", longint'(t_ready), 1);

    directed("half",   16384, 0,     1000, 32767, 255,  1'b0);
    directed("half_t", 16384, 0,     4095, 32767, 255,  1'b0);
    directed("lin",    0,     32767, 2048, 32767, 255,  1'b0);
    directed("sat",    32767, 32767, 4095, 32767, 511,  1'b1);
    directed("neg",    -32768, 0,    100,  32767, -512, 1'b0);

    for (int s = 0; s < 4; s++) begin
      rand_set(s + 1);
      load_cs();
      rand_stream(150);
    end
    wait_empty();

    // Ramp with a new set written mid-stream and committed together with the last write
    rand_set(2);
    load_cs();
    for (int k = 0; k <= N; k++) new_cs[k] = longint'($signed(BC'($urandom))) >>> 2;
    low_cnt = 0;
    acc_cnt = 0;
    for (int i = 0; i < 2048; i++) begin
      t_in     = BT'(i);
      g_in     = BC'(20000);
      t_valid  = 1'b1;
      c_we     = 1'b0;
      c_commit = 1'b0;
      if (i >= 600 && i < 600 + N) begin
        c_we = 1'b1; c_addr = AW'(i - 600); c_data = BC'(new_cs[i - 600]);
        m_shadow[i - 600] = new_cs[i - 600];
      end else if (i == 1000) begin
        c_we = 1'b1; c_addr = AW'(N); c_data = BC'(new_cs[N]);
        m_shadow[N] = new_cs[N];
        c_commit = 1'b1;
      end
      if (t_ready) acc_cnt++;
      else low_cnt++;
      tick();
    end
    t_valid = 1'b0; c_we = 1'b0; c_commit = 1'b0;
    check_val("ramp_ready_low_range", longint'(low_cnt >= 2 && low_cnt <= N + 3), 1);
    check_val("ramp_accepted", acc_cnt, 2048 - low_cnt);
    wait_empty();

    // Reset in the middle of a dense stream
    for (int i = 0; i < 60; i++) begin
      t_in    = BT'($urandom);
      g_in    = BC'(32767);
      t_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    #1;
    check_val("midrst_y_valid", longint'(y_valid), 0);
    check_val("midrst_y_out", longint'(y_out), 0);
    check_val("midrst_ovf", longint'(ovf), 0);
    check_val("midrst_t_ready", longint'(t_ready), 0);
    eq.delete();
    for (int k = 0; k <= N; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end
    t_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    check_val("rel_ready_before_edge", longint'(t_ready), 0);
    tick();
    check_val("rel_ready_after_edge", longint'(t_ready), 1);
    send_one(1234, 32767, y, o);
    check_val("banks_cleared_y", y, 0);
    check_val("banks_cleared_ovf", longint'(o), 0);
    rand_stream(40);
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
